// File: rtl/sprite_rom_bank_reader.sv
// sprite_rom_bank_reader
// Read port for a bank of synchronous sprite-frame ROMs. One address fans out
// to every ROM; a tag pipeline matched to the ROM latency carries the select
// so the correct ROM word is picked when its data appears. An optional
// animation mode steps the selected frame on each frame tick.
module sprite_rom_bank_reader #(
  parameter int NUM_ROMS    = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int ID_WIDTH    = 4,
  parameter int ROM_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req,
  input  logic [ID_WIDTH-1:0]            romId,
  input  logic [ADDR_WIDTH-1:0]          romAddr,
  input  logic                           animEnable,
  input  logic                           frameTick,
  input  logic [ID_WIDTH-1:0]            frameLast,
  output logic [ADDR_WIDTH-1:0]          romAddrOut,
  input  logic [NUM_ROMS*DATA_WIDTH-1:0] romDataBus,
  output logic                           readValid,
  output logic [DATA_WIDTH-1:0]          readData,
  output logic [ID_WIDTH-1:0]            currentFrame,
  output logic                           selErr
);

  // Highest frame index that maps onto a real ROM, and the ROM count widened
  // by one bit so a full 2^ID_WIDTH bank still compares correctly.
  localparam logic [ID_WIDTH-1:0] MAX_FRAME = ID_WIDTH'(NUM_ROMS - 1);
  localparam logic [ID_WIDTH:0]   ROM_COUNT = (ID_WIDTH + 1)'(NUM_ROMS);

  logic [ID_WIDTH-1:0]   eff_sel;
  logic [ID_WIDTH-1:0]   frame_limit;
  logic                  tag_valid [ROM_LATENCY];
  logic [ID_WIDTH-1:0]   tag_sel   [ROM_LATENCY];
  logic                  out_valid;
  logic [ID_WIDTH-1:0]   out_sel;
  logic                  out_in_range;
  logic [DATA_WIDTH-1:0] sel_word;

  // The ROM IP registers the address itself, so it is passed straight through.
  assign romAddrOut = romAddr;

  // Animation mode reads the frame that is current in the request cycle,
  // i.e. before any increment caused by a coincident tick.
  assign eff_sel = animEnable ? currentFrame : romId;

  // Wrap point is the smaller of the requested last frame and the last ROM.
  assign frame_limit = (frameLast < MAX_FRAME) ? frameLast : MAX_FRAME;

  // Tag shift register: one stage per cycle of ROM latency, never stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_sel[i]   <= '0;
      end
    end else begin
      tag_valid[0] <= req;
      tag_sel[0]   <= eff_sel;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_sel[i]   <= tag_sel[i-1];
      end
    end
  end

  assign out_valid    = tag_valid[ROM_LATENCY-1];
  assign out_sel      = tag_sel[ROM_LATENCY-1];
  assign out_in_range = {1'b0, out_sel} < ROM_COUNT;

  // Pick the ROM word named by the emerging tag; an unmatched select falls
  // through to the default word.
  always_comb begin
    sel_word = DEFAULT_DATA;
    for (int k = 0; k < NUM_ROMS; k++) begin
      if (out_sel == ID_WIDTH'(k)) begin
        sel_word = romDataBus[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register: data only updates on a valid tag; the error flag is
  // sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      readValid <= 1'b0;
      readData  <= '0;
      selErr    <= 1'b0;
    end else begin
      readValid <= out_valid;
      if (out_valid) begin
        readData <= sel_word;
      end
      if (out_valid && !out_in_range) begin
        selErr <= 1'b1;
      end
    end
  end

  // Frame index: parked at zero outside animation mode, advances and wraps
  // on each tick while animating.
  always_ff @(posedge clock) begin
    if (reset) begin
      currentFrame <= '0;
    end else if (!animEnable) begin
      currentFrame <= '0;
    end else if (frameTick) begin
      if (currentFrame >= frame_limit) begin
        currentFrame <= '0;
      end else begin
        currentFrame <= currentFrame + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_bank_reader.sv
// Testbench for sprite_rom_bank_reader: two instances (ROM latency 1 and 2)
// share one stimulus stream, each with its own ROM model and scoreboard queue.
module tb_sprite_rom_bank_reader;

  localparam int NR = 3;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req;
  logic [IW-1:0] romId;
  logic [AW-1:0] romAddr;
  logic          animEnable;
  logic          frameTick;
  logic [IW-1:0] frameLast;

  logic [AW-1:0]    addr_out_a, addr_out_b;
  logic [NR*DW-1:0] bus_a, bus_b;
  logic             valid_a, valid_b;
  logic [DW-1:0]    data_a, data_b;
  logic [IW-1:0]    frame_a, frame_b;
  logic             err_a, err_b;

  typedef struct {
    logic [DW-1:0] data;
    int            issue;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [AW-1:0] rom_addr_a;
  logic [AW-1:0] rom_addr_b [2];

  sprite_rom_bank_reader #(
    .NUM_ROMS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .ROM_LATENCY(1), .DEFAULT_DATA(16'h0000)
  ) dut_a (
    .clock(clock), .reset(reset), .req(req), .romId(romId), .romAddr(romAddr),
    .animEnable(animEnable), .frameTick(frameTick), .frameLast(frameLast),
    .romAddrOut(addr_out_a), .romDataBus(bus_a), .readValid(valid_a),
    .readData(data_a), .currentFrame(frame_a), .selErr(err_a)
  );

  sprite_rom_bank_reader #(
    .NUM_ROMS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .ROM_LATENCY(2), .DEFAULT_DATA(16'h0000)
  ) dut_b (
    .clock(clock), .reset(reset), .req(req), .romId(romId), .romAddr(romAddr),
    .animEnable(animEnable), .frameTick(frameTick), .frameLast(frameLast),
    .romAddrOut(addr_out_b), .romDataBus(bus_b), .readValid(valid_b),
    .readData(data_b), .currentFrame(frame_b), .selErr(err_b)
  );

  always #5 clock = ~clock;

  // Cycle counter used to check request-to-result latency.
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous ROM models: latency 1 for instance A, latency 2 for B.
  always @(posedge clock) begin
    rom_addr_a    <= addr_out_a;
    rom_addr_b[0] <= addr_out_b;
    rom_addr_b[1] <= rom_addr_b[0];
  end

  // ROM k returns 0x1000 + k*0x100 + address.
  always_comb begin
    bus_a = '0;
    bus_b = '0;
    for (int k = 0; k < NR; k++) begin
      bus_a[k*DW +: DW] = 16'h1000 + 16'(k * 256) + rom_addr_a;
      bus_b[k*DW +: DW] = 16'h1000 + 16'(k * 256) + rom_addr_b[1];
    end
  end

  // Monitor for instance A: every readValid must match the oldest expectation.
  always @(negedge clock) begin
    if (valid_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid_a: readValid=1 in cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        checks++;
        if (data_a !== e.data) begin
          errors++;
          $display("[TB] FAIL data_a: got %h, required %h (issued cycle %0d)", data_a, e.data, e.issue);
        end
        checks++;
        if (cyc != e.issue + 2) begin
          errors++;
          $display("[TB] FAIL latency_a: result in cycle %0d, required %0d", cyc, e.issue + 2);
        end
      end
    end
  end

  // Monitor for instance B, same checks with one extra cycle of latency.
  always @(negedge clock) begin
    if (valid_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid_b: readValid=1 in cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        checks++;
        if (data_b !== e.data) begin
          errors++;
          $display("[TB] FAIL data_b: got %h, required %h (issued cycle %0d)", data_b, e.data, e.issue);
        end
        checks++;
        if (cyc != e.issue + 3) begin
          errors++;
          $display("[TB] FAIL latency_b: result in cycle %0d, required %0d", cyc, e.issue + 3);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  // Issue one read for one cycle and queue its hand-computed result.
  task automatic applyStimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                               input logic [DW-1:0] exp_data, input logic tick);
    req       = 1'b1;
    romId     = id;
    romAddr   = addr;
    frameTick = tick;
    qa.push_back('{data: exp_data, issue: cyc});
    qb.push_back('{data: exp_data, issue: cyc});
    step();
    req       = 1'b0;
    frameTick = 1'b0;
  endtask

  task automatic pulseTick();
    frameTick = 1'b1;
    step();
    frameTick = 1'b0;
  endtask

  task automatic checkFrame(input string name, input logic [IW-1:0] want);
    checkOutput({name, "_a"}, 32'(frame_a), 32'(want));
    checkOutput({name, "_b"}, 32'(frame_b), 32'(want));
  endtask

  task automatic checkErr(input string name, input logic want);
    checkOutput({name, "_a"}, 32'(err_a), 32'(want));
    checkOutput({name, "_b"}, 32'(err_b), 32'(want));
  endtask

  // Directed sequence: reset, manual reads, out-of-range, animation, reset drop.
  initial begin
    reset      = 1'b1;
    req        = 1'b0;
    romId      = '0;
    romAddr    = '0;
    animEnable = 1'b0;
    frameTick  = 1'b0;
    frameLast  = 4'd7;
    idle(3);
    reset = 1'b0;
    checkOutput("reset_valid_a", 32'(valid_a), 0);
    checkOutput("reset_valid_b", 32'(valid_b), 0);
    checkOutput("reset_data_a", 32'(data_a), 0);
    checkOutput("reset_data_b", 32'(data_b), 0);
    checkErr("reset_selerr", 1'b0);
    checkFrame("reset_frame", 4'd0);
    idle(3);

    applyStimulus(4'd2, 16'd5, 16'h1205, 1'b0);
    idle(4);

    applyStimulus(4'd0, 16'd1, 16'h1001, 1'b0);
    applyStimulus(4'd1, 16'd2, 16'h1102, 1'b0);
    applyStimulus(4'd2, 16'd3, 16'h1203, 1'b0);
    applyStimulus(4'd0, 16'd4, 16'h1004, 1'b0);
    idle(4);
    checkErr("selerr_before_oor", 1'b0);

    applyStimulus(4'd3, 16'd6, 16'h0000, 1'b0);
    idle(4);
    checkErr("selerr_set", 1'b1);
    applyStimulus(4'd1, 16'd7, 16'h1107, 1'b0);
    idle(4);
    checkErr("selerr_sticky", 1'b1);

    animEnable = 1'b1;
    frameLast  = 4'd7;
    step();
    checkFrame("anim_start", 4'd0);
    idle(3);
    pulseTick();
    checkFrame("anim_tick1", 4'd1);
    idle(1);
    applyStimulus(4'd0, 16'h000B, 16'h110B, 1'b0);
    idle(1);
    pulseTick();
    checkFrame("anim_tick2", 4'd2);
    idle(3);
    applyStimulus(4'd0, 16'd9, 16'h1209, 1'b1);
    checkFrame("anim_tick3_clamp", 4'd0);
    idle(3);
    pulseTick();
    checkFrame("anim_tick4", 4'd1);

    frameLast = 4'd0;
    idle(2);
    pulseTick();
    checkFrame("framelast_below", 4'd0);
    frameLast = 4'd7;
    pulseTick();
    checkFrame("framelast_restored", 4'd1);
    animEnable = 1'b0;
    step();
    checkFrame("anim_off", 4'd0);
    idle(4);

    req     = 1'b1;
    romId   = 4'd1;
    romAddr = 16'd3;
    step();
    req   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkErr("post_reset_selerr", 1'b0);
    checkFrame("post_reset_frame", 4'd0);
    idle(6);

    checkOutput("queue_a_drained", 32'(qa.size()), 0);
    checkOutput("queue_b_drained", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
